// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core.
package idli_pkg;

   // One SQI bus nibble.
   typedef logic [3:0] sqi_data_t;

   // Instruction fetch sequencer states.
   typedef enum logic [2:0] {
      FETCH_IDLE  = 3'd0,
      FETCH_CMD   = 3'd1,
      FETCH_ADDR  = 3'd2,
      FETCH_DUMMY = 3'd3,
      FETCH_DATA  = 3'd4
   } fetch_state_t;

   // SRAM read command and transaction framing.
   localparam logic [7:0] SQI_CMD_READ      = 8'h03;
   localparam int         SQI_ADDR_NIBBLES  = 6;
   localparam int         SQI_DUMMY_NIBBLES = 2;

endpackage

// File: rtl/idli_fetch_m.sv
// Instruction fetch sequencer: issues SQI reads to the instruction SRAM and
// streams 16b instructions to the decoder as four nibbles, MSN first.
// Redirects and stalls are only honoured between instructions.
module idli_fetch_m
   import idli_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        i_fetch_gck,
   input  logic        i_fetch_rst_n,
   output logic        o_fetch_sqi_cs_n,
   output logic        o_fetch_sqi_oe,
   output sqi_data_t   o_fetch_sqi_data,
   input  sqi_data_t   i_fetch_sqi_data,
   output sqi_data_t   o_fetch_enc,
   output logic        o_fetch_enc_vld,
   output logic [15:0] o_fetch_pc,
   input  logic        i_fetch_stall,
   input  logic        i_fetch_redir,
   input  logic [15:0] i_fetch_redir_pc
);

   fetch_state_t state, state_d;
   logic [2:0]   phase, phase_d;
   logic [1:0]   nib, nib_d;
   logic [15:0]  pc, pc_d;
   logic [23:0]  addr_sr, addr_d;
   logic         redir_pend, pend_d;
   logic [15:0]  redir_pc_q, rpc_d;
   logic         redir_now;
   logic [15:0]  redir_tgt;

   // A same-cycle pulse takes precedence over (and overwrites) a pending one.
   assign redir_now = i_fetch_redir | redir_pend;
   assign redir_tgt = i_fetch_redir ? i_fetch_redir_pc : redir_pc_q;

   // State, counters, address shifter and redirect latch.
   always_ff @(posedge i_fetch_gck or negedge i_fetch_rst_n) begin
      if (!i_fetch_rst_n) begin
         state      <= FETCH_IDLE;
         phase      <= 3'd0;
         nib        <= 2'd0;
         pc         <= RESET_PC;
         addr_sr    <= 24'd0;
         redir_pend <= 1'b0;
         redir_pc_q <= 16'd0;
      end else begin
         state      <= state_d;
         phase      <= phase_d;
         nib        <= nib_d;
         pc         <= pc_d;
         addr_sr    <= addr_d;
         redir_pend <= pend_d;
         redir_pc_q <= rpc_d;
      end
   end

   // Next-state sequencing and bus outputs.
   always_comb begin
      state_d          = state;
      phase_d          = phase;
      nib_d            = nib;
      pc_d             = pc;
      addr_d           = addr_sr;
      pend_d           = redir_now;
      rpc_d            = redir_tgt;
      o_fetch_sqi_cs_n = 1'b0;
      o_fetch_sqi_oe   = 1'b0;
      o_fetch_sqi_data = 4'h0;
      o_fetch_enc_vld  = 1'b0;

      case (state)
         FETCH_IDLE: begin
            o_fetch_sqi_cs_n = 1'b1;
            phase_d          = 3'd0;
            nib_d            = 2'd0;
            if (redir_now) begin
               // Take the target now; the next IDLE cycle launches the fetch.
               pc_d   = redir_tgt;
               pend_d = 1'b0;
            end else if (!i_fetch_stall) begin
               state_d = FETCH_CMD;
               addr_d  = {7'b0, pc, 1'b0};
            end
         end

         FETCH_CMD: begin
            o_fetch_sqi_oe   = 1'b1;
            o_fetch_sqi_data = phase[0] ? SQI_CMD_READ[3:0] : SQI_CMD_READ[7:4];
            if (redir_now) begin
               state_d = FETCH_IDLE;
               pc_d    = redir_tgt;
               pend_d  = 1'b0;
               phase_d = 3'd0;
            end else if (phase == 3'd1) begin
               state_d = FETCH_ADDR;
               phase_d = 3'd0;
            end else begin
               phase_d = phase + 3'd1;
            end
         end

         FETCH_ADDR: begin
            o_fetch_sqi_oe   = 1'b1;
            o_fetch_sqi_data = addr_sr[23:20];
            addr_d           = {addr_sr[19:0], 4'h0};
            if (redir_now) begin
               state_d = FETCH_IDLE;
               pc_d    = redir_tgt;
               pend_d  = 1'b0;
               phase_d = 3'd0;
            end else if (phase == 3'(SQI_ADDR_NIBBLES - 1)) begin
               state_d = FETCH_DUMMY;
               phase_d = 3'd0;
            end else begin
               phase_d = phase + 3'd1;
            end
         end

         FETCH_DUMMY: begin
            if (redir_now) begin
               state_d = FETCH_IDLE;
               pc_d    = redir_tgt;
               pend_d  = 1'b0;
               phase_d = 3'd0;
            end else if (phase == 3'(SQI_DUMMY_NIBBLES - 1)) begin
               state_d = FETCH_DATA;
               phase_d = 3'd0;
               nib_d   = 2'd0;
            end else begin
               phase_d = phase + 3'd1;
            end
         end

         FETCH_DATA: begin
            o_fetch_enc_vld = 1'b1;
            nib_d           = nib + 2'd1;
            if (nib == 2'd3) begin
               pend_d = 1'b0;
               if (redir_now) begin
                  pc_d    = redir_tgt;
                  state_d = FETCH_IDLE;
               end else begin
                  pc_d = pc + 16'd1;
                  // The SRAM burst does not wrap at the top of the array.
                  if (pc == 16'hFFFF || i_fetch_stall)
                     state_d = FETCH_IDLE;
               end
            end
         end

         default: begin
            state_d = FETCH_IDLE;
         end
      endcase
   end

   assign o_fetch_enc = i_fetch_sqi_data;
   assign o_fetch_pc  = pc;

endmodule
